// File: rtl/tone_pkg.sv
// Shared types and helpers for the tone sequencer.
// Holds the playback state encoding and the frame-size helper.
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    function automatic int frame_bits(
        input int notes,
        input int div_w,
        input int dur_w
    );
        return notes * (div_w + dur_w);
    endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// SPI frame receiver: synchronizes sck/sdi/load into clk, shifts a frame.
// Ports: clk, reset_n, sck, sdi, load in; frame_o, commit_o, frame_err_o out.
module spi_frame_rx #(
    parameter int FB = 24
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sck,
    input  logic          sdi,
    input  logic          load,
    output logic [FB-1:0] frame_o,
    output logic          commit_o,
    output logic          frame_err_o
);
    import tone_pkg::*;

    localparam int CW = $clog2(FB + 2);

    // [0],[1] synchronizer, [2] edge-detect history
    logic [2:0]    sck_q, sck_d;
    logic [2:0]    load_q, load_d;
    logic [1:0]    sdi_q, sdi_d;
    logic [FB-1:0] sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic sck_rise;
    logic load_s;
    logic load_rise;
    logic load_fall;

    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign load_s    = load_q[1];
    assign load_rise = load_q[1] & ~load_q[2];
    assign load_fall = ~load_q[1] & load_q[2];

    always_comb begin
        sck_d  = {sck_q[1:0], sck};
        load_d = {load_q[1:0], load};
        sdi_d  = {sdi_q[0], sdi};
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        if (sck_rise && load_s) begin
            sr_d = {sr_q[FB-2:0], sdi_q[1]};
            if (cnt_q != CW'(FB + 1)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (load_rise) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_q  <= '0;
            load_q <= '0;
            sdi_q  <= '0;
            sr_q   <= '0;
            cnt_q  <= '0;
        end else begin
            sck_q  <= sck_d;
            load_q <= load_d;
            sdi_q  <= sdi_d;
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign frame_o     = sr_q;
    assign commit_o    = load_fall && (cnt_q == CW'(FB));
    assign frame_err_o = load_fall && (cnt_q != CW'(FB));

endmodule

// File: rtl/tone_sequencer.sv
// Note sequencer: buffers an SPI frame of {div,dur} notes, plays them on pwm.
// Ports: clk, reset_n, sck, sdi, load in; pwm, busy, done, frame_err out.
// Build option: TONE_LOOP_EN repeats the sequence forever instead of done.
module tone_sequencer #(
    parameter int NOTES    = 8,
    parameter int DIV_W    = 16,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 48000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sck,
    input  logic sdi,
    input  logic load,
    output logic pwm,
    output logic busy,
    output logic done,
    output logic frame_err
);
    import tone_pkg::*;

    localparam int NW = DIV_W + DUR_W;
    localparam int FB = frame_bits(NOTES, DIV_W, DUR_W);
    localparam int IW = (NOTES > 1) ? $clog2(NOTES) : 1;
    localparam int TW = $clog2(TICK_DIV + 1);

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [DUR_W-1:0] dur;
    } note_t;

    logic [FB-1:0] frame;
    logic          commit;

    spi_frame_rx #(
        .FB (FB)
    ) u_rx (
        .clk         (clk),
        .reset_n     (reset_n),
        .sck         (sck),
        .sdi         (sdi),
        .load        (load),
        .frame_o     (frame),
        .commit_o    (commit),
        .frame_err_o (frame_err)
    );

    note_t            buf_q [NOTES];
    note_t            buf_d [NOTES];
    note_t            frm   [NOTES];
    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [DUR_W-1:0] durc_q, durc_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic             pwm_q, pwm_d;
    logic             done_q, done_d;

    note_t         cur;
    logic          tick_end;
    logic [IW-1:0] cf, nf;
    logic          cf_ok, nf_ok;

    assign cur      = buf_q[idx_q];
    assign tick_end = (tick_q == TW'(TICK_DIV - 1));

    // Note 0 is the most significant field of the frame
    always_comb begin
        for (int i = 0; i < NOTES; i++) begin
            frm[i] = frame[FB-1-i*NW -: NW];
        end
    end

    // Zero-duration notes are skipped when choosing where to go next
    always_comb begin
        cf    = '0;
        cf_ok = 1'b0;
        nf    = '0;
        nf_ok = 1'b0;
        for (int i = NOTES - 1; i >= 0; i--) begin
            if (frm[i].dur != '0) begin
                cf    = IW'(i);
                cf_ok = 1'b1;
            end
            if (i > int'(idx_q) && buf_q[i].dur != '0) begin
                nf    = IW'(i);
                nf_ok = 1'b1;
            end
        end
    end

`ifdef TONE_LOOP_EN
    logic [IW-1:0] wf;

    always_comb begin
        wf = '0;
        for (int i = NOTES - 1; i >= 0; i--) begin
            if (buf_q[i].dur != '0) begin
                wf = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        buf_d   = buf_q;
        state_d = state_q;
        idx_d   = idx_q;
        tick_d  = tick_q;
        durc_d  = durc_q;
        half_d  = half_q;
        pwm_d   = pwm_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
            end
            ST_PLAY: begin
                if (cur.dur == '0) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    pwm_d   = 1'b0;
`ifndef TONE_LOOP_EN
                    done_d  = 1'b1;
`endif
                end else if (tick_end &&
                             durc_q == cur.dur - DUR_W'(1)) begin
                    state_d = ST_GAP;
                    tick_d  = '0;
                    durc_d  = '0;
                    half_d  = '0;
                    pwm_d   = 1'b0;
                end else begin
                    if (tick_end) begin
                        tick_d = '0;
                        durc_d = durc_q + DUR_W'(1);
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                    if (cur.div == '0) begin
                        half_d = '0;
                        pwm_d  = 1'b0;
                    end else if (half_q == cur.div - DIV_W'(1)) begin
                        half_d = '0;
                        pwm_d  = ~pwm_q;
                    end else begin
                        half_d = half_q + DIV_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick_end) begin
                    tick_d = '0;
                    durc_d = '0;
                    half_d = '0;
                    pwm_d  = 1'b0;
                    if (nf_ok) begin
                        state_d = ST_PLAY;
                        idx_d   = nf;
                    end else begin
`ifdef TONE_LOOP_EN
                        state_d = ST_PLAY;
                        idx_d   = wf;
`else
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
`endif
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                pwm_d   = 1'b0;
            end
        endcase

        // A new frame overrides whatever the player was doing
        if (commit) begin
            buf_d  = frm;
            tick_d = '0;
            durc_d = '0;
            half_d = '0;
            pwm_d  = 1'b0;
            done_d = 1'b0;
            idx_d  = cf;
            if (cf_ok) begin
                state_d = ST_PLAY;
            end else begin
`ifdef TONE_LOOP_EN
                state_d = ST_IDLE;
`else
                state_d = ST_PLAY;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NOTES; i++) begin
                buf_q[i] <= '0;
            end
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tick_q  <= '0;
            durc_q  <= '0;
            half_q  <= '0;
            pwm_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            durc_q  <= durc_d;
            half_q  <= half_d;
            pwm_q   <= pwm_d;
            done_q  <= done_d;
        end
    end

    assign pwm  = pwm_q;
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule
